// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: register index and the pipeline controller
// FSM state encoding used by pipeline_ctrl.
package rv32i_types;

    // Architectural register index (x0..x31)
    typedef logic [4:0] rv32i_reg;

    // Pipeline controller states; codes 2'b10 and 2'b11 are unused
    typedef enum logic [1:0] {
        CTRL_RUN      = 2'b00,
        CTRL_MEM_WAIT = 2'b01
    } ctrl_state_t;

    // Width of the optional performance counters
    localparam int PERF_CNT_W = 32;

    // x0 is hardwired to zero, so it never carries a real dependency
    function automatic logic reg_is_live(input rv32i_reg r);
        return (r != 5'd0);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// hazard_detect: purely combinational load-use detector. Flags the case
// where the instruction in EX is a load whose destination is read by the
// instruction currently in ID.
import rv32i_types::*;

module hazard_detect (
    input  logic     ex_is_load,
    input  rv32i_reg ex_rd,
    input  rv32i_reg id_rs1,
    input  rv32i_reg id_rs2,
    input  logic     id_uses_rs1,
    input  logic     id_uses_rs2,
    output logic     load_use
);

    logic match_rs1;
    logic match_rs2;

    // Compare the load destination against each source actually read in ID
    always_comb begin
        match_rs1 = id_uses_rs1 && (ex_rd == id_rs1);
        match_rs2 = id_uses_rs2 && (ex_rd == id_rs2);
        load_use  = ex_is_load && reg_is_live(ex_rd) && (match_rs1 || match_rs2);
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush controller for a 5-stage RV32I pipeline.
// Freezes the whole pipeline while an instruction or data memory access is
// outstanding, inserts one bubble per load-use hazard and flushes IF/ID and
// ID/EX on a taken branch. Outputs are combinational so a stall takes
// effect in the same cycle it is detected.
// Optional feature: define PIPE_CTRL_PERF_EN to add 32-bit performance
// counters perf_stall_cycles, perf_lu_count and perf_flush_count.
import rv32i_types::*;

module pipeline_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  rv32i_reg    id_rs1,
    input  rv32i_reg    id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  rv32i_reg    ex_rd,
    input  logic        ex_is_load,
    input  logic        ex_br_taken,
    input  logic        imem_req,
    input  logic        imem_resp,
    input  logic        dmem_req,
    input  logic        dmem_resp,
    output logic        load_pc,
    output logic        load_if_id,
    output logic        load_id_ex,
    output logic        load_ex_mem,
    output logic        load_mem_wb,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic [1:0]  ctrl_state_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] perf_stall_cycles,
    output logic [PERF_CNT_W-1:0] perf_lu_count,
    output logic [PERF_CNT_W-1:0] perf_flush_count
`endif
);

    localparam logic [1:0] ST_RUN      = CTRL_RUN;
    localparam logic [1:0] ST_MEM_WAIT = CTRL_MEM_WAIT;

    logic [1:0] state;
    logic [1:0] state_next;
    logic       imem_done;
    logic       dmem_done;
    logic       imem_done_next;
    logic       dmem_done_next;
    logic       outstanding_i;
    logic       outstanding_d;
    logic       miss;
    logic       load_use;
    logic       lu_bubble;

    hazard_detect u_hazard (
        .ex_is_load  (ex_is_load),
        .ex_rd       (ex_rd),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .load_use    (load_use)
    );

    // A side is outstanding if it is requesting and has neither just been
    // answered nor been answered earlier in this wait (sticky flag)
    always_comb begin
        outstanding_i = imem_req && !imem_resp && !imem_done;
        outstanding_d = dmem_req && !dmem_resp && !dmem_done;
        miss          = outstanding_i || outstanding_d;
    end

    // Next-state and sticky-flag logic; flags only accumulate while waiting
    // and are dropped on the cycle the wait is released
    always_comb begin
        state_next     = ST_RUN;
        imem_done_next = 1'b0;
        dmem_done_next = 1'b0;
        case (state)
            ST_RUN: begin
                state_next = miss ? ST_MEM_WAIT : ST_RUN;
            end
            ST_MEM_WAIT: begin
                if (miss) begin
                    state_next     = ST_MEM_WAIT;
                    imem_done_next = imem_done || (imem_req && imem_resp);
                    dmem_done_next = dmem_done || (dmem_req && dmem_resp);
                end else begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // State and flag registers; reset abandons any wait immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            imem_done <= 1'b0;
            dmem_done <= 1'b0;
        end else begin
            state     <= state_next;
            imem_done <= imem_done_next;
            dmem_done <= dmem_done_next;
        end
    end

    // Enable/flush decode: memory miss freezes everything, then taken
    // branch beats load-use, otherwise the pipeline advances normally
    always_comb begin
        load_pc     = 1'b0;
        load_if_id  = 1'b0;
        load_id_ex  = 1'b0;
        load_ex_mem = 1'b0;
        load_mem_wb = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        lu_bubble   = 1'b0;
        if (rst_n && !miss) begin
            load_pc     = 1'b1;
            load_if_id  = 1'b1;
            load_id_ex  = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
            if (ex_br_taken) begin
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end else if (load_use) begin
                load_pc     = 1'b0;
                load_if_id  = 1'b0;
                flush_id_ex = 1'b1;
                lu_bubble   = 1'b1;
            end
        end
    end

    assign ctrl_state_o = state;

`ifdef PIPE_CTRL_PERF_EN
    // Free-running event counters, wrapping naturally at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cycles <= '0;
            perf_lu_count     <= '0;
            perf_flush_count  <= '0;
        end else begin
            if (!load_pc)
                perf_stall_cycles <= perf_stall_cycles + 1'b1;
            if (lu_bubble)
                perf_lu_count <= perf_lu_count + 1'b1;
            if (flush_if_id)
                perf_flush_count <= perf_flush_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: the driver pushes hand-computed
// expectations per cycle, a monitor pops and compares on the falling edge.
import rv32i_types::*;

module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    rv32i_reg   id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_is_load, ex_br_taken;
    logic       imem_req, imem_resp, dmem_req, dmem_resp;
    logic       load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic       flush_if_id, flush_id_ex;
    logic [1:0] ctrl_state_o;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cycles, perf_lu_count, perf_flush_count;
`endif

    int checks = 0;
    int fails  = 0;

    typedef struct {
        string      name;
        logic [4:0] ld;   // {pc, if_id, id_ex, ex_mem, mem_wb}
        logic [1:0] fl;   // {flush_if_id, flush_id_ex}
        logic [1:0] st;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .ex_rd        (ex_rd),
        .ex_is_load   (ex_is_load),
        .ex_br_taken  (ex_br_taken),
        .imem_req     (imem_req),
        .imem_resp    (imem_resp),
        .dmem_req     (dmem_req),
        .dmem_resp    (dmem_resp),
        .load_pc      (load_pc),
        .load_if_id   (load_if_id),
        .load_id_ex   (load_id_ex),
        .load_ex_mem  (load_ex_mem),
        .load_mem_wb  (load_mem_wb),
        .flush_if_id  (flush_if_id),
        .flush_id_ex  (flush_id_ex),
        .ctrl_state_o (ctrl_state_o)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_lu_count     (perf_lu_count),
        .perf_flush_count  (perf_flush_count)
`endif
    );

    // Monitor: outputs are combinational, so each cycle presents a result
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [4:0] ld_a;
            logic [1:0] fl_a;
            e    = sb.pop_front();
            ld_a = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb};
            fl_a = {flush_if_id, flush_id_ex};
            checks = checks + 3;
            if (ld_a !== e.ld) begin
                fails = fails + 1;
                $display("FAIL %s loads: got %b want %b", e.name, ld_a, e.ld);
            end
            if (fl_a !== e.fl) begin
                fails = fails + 1;
                $display("FAIL %s flushes: got %b want %b", e.name, fl_a, e.fl);
            end
            if (ctrl_state_o !== e.st) begin
                fails = fails + 1;
                $display("FAIL %s state: got %0d want %0d", e.name, ctrl_state_o, e.st);
            end
        end
    end

    // Queue this cycle's expectation, then advance to just after the next edge
    task automatic cyc(input string name, input logic [4:0] ld,
                       input logic [1:0] fl, input logic [1:0] st);
        exp_t e;
        e.name = name; e.ld = ld; e.fl = fl; e.st = st;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_is_load = 1'b0; ex_br_taken = 1'b0;
        imem_req = 1'b0; imem_resp = 1'b0; dmem_req = 1'b0; dmem_resp = 1'b0;
    endtask

    task automatic set_lu(input rv32i_reg rd);
        ex_is_load = 1'b1; ex_rd = rd; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        @(posedge clk); #1;
        // Reset state, even with a request pending
        cyc("reset_idle", 5'b00000, 2'b00, 2'd0);
        imem_req = 1'b1;
        cyc("reset_req", 5'b00000, 2'b00, 2'd0);
        idle_inputs();
        rst_n = 1'b1;

        cyc("run_idle", 5'b11111, 2'b00, 2'd0);

        // Load-use on rs1: one bubble, then free flow
        set_lu(5'd5);
        cyc("lu_rs1", 5'b00111, 2'b01, 2'd0);
        idle_inputs();
        cyc("lu_after", 5'b11111, 2'b00, 2'd0);

        // Load-use on rs2 only
        ex_is_load = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b1;
        cyc("lu_rs2", 5'b00111, 2'b01, 2'd0);
        // Matching rs1 that is not actually read: no hazard
        idle_inputs();
        ex_is_load = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b0;
        cyc("lu_unused", 5'b11111, 2'b00, 2'd0);

        // Load to x0 never stalls
        idle_inputs();
        set_lu(5'd0);
        cyc("lu_x0", 5'b11111, 2'b00, 2'd0);

        // Taken branch beats load-use
        set_lu(5'd5);
        ex_br_taken = 1'b1;
        cyc("br_over_lu", 5'b11111, 2'b11, 2'd0);
        idle_inputs();

        // Both sides miss: imem_resp at cycle 3, dmem_resp at cycle 6
        imem_req = 1'b1; dmem_req = 1'b1;
        cyc("dual_c0", 5'b00000, 2'b00, 2'd0);
        cyc("dual_c1", 5'b00000, 2'b00, 2'd1);
        cyc("dual_c2", 5'b00000, 2'b00, 2'd1);
        imem_resp = 1'b1;
        cyc("dual_c3", 5'b00000, 2'b00, 2'd1);
        imem_resp = 1'b0;
        cyc("dual_c4", 5'b00000, 2'b00, 2'd1);
        cyc("dual_c5", 5'b00000, 2'b00, 2'd1);
        dmem_resp = 1'b1;
        cyc("dual_c6", 5'b11111, 2'b00, 2'd1);
        idle_inputs();
        cyc("dual_c7", 5'b11111, 2'b00, 2'd0);

        // Taken branch held during a 4-cycle dmem miss
        dmem_req = 1'b1; ex_br_taken = 1'b1;
        cyc("brmiss_c0", 5'b00000, 2'b00, 2'd0);
        cyc("brmiss_c1", 5'b00000, 2'b00, 2'd1);
        cyc("brmiss_c2", 5'b00000, 2'b00, 2'd1);
        cyc("brmiss_c3", 5'b00000, 2'b00, 2'd1);
        dmem_resp = 1'b1;
        cyc("brmiss_rel", 5'b11111, 2'b11, 2'd1);
        idle_inputs();
        cyc("brmiss_after", 5'b11111, 2'b00, 2'd0);

        // Response without request is ignored
        imem_resp = 1'b1; dmem_resp = 1'b1;
        cyc("resp_noreq", 5'b11111, 2'b00, 2'd0);
        idle_inputs();

        // Reset in the middle of a wait
        imem_req = 1'b1;
        cyc("rstwait_c0", 5'b00000, 2'b00, 2'd0);
        cyc("rstwait_c1", 5'b00000, 2'b00, 2'd1);
        rst_n = 1'b0;
        #1;
        cyc("rstwait_rst", 5'b00000, 2'b00, 2'd0);
        cyc("rstwait_hold", 5'b00000, 2'b00, 2'd0);
        imem_req = 1'b0;
        rst_n = 1'b1;
        cyc("rstwait_rel", 5'b11111, 2'b00, 2'd0);

`ifdef PIPE_CTRL_PERF_EN
        // Stall counter wraps from all-ones to zero
        dut.perf_stall_cycles = 32'hFFFF_FFFF;
        set_lu(5'd5);
        cyc("perf_lu", 5'b00111, 2'b01, 2'd0);
        idle_inputs();
        checks = checks + 1;
        if (perf_stall_cycles !== 32'd0) begin
            fails = fails + 1;
            $display("FAIL perf_wrap: got %h want 00000000", perf_stall_cycles);
        end
`endif

        // Drain the scoreboard, bounded
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            checks = checks + 1;
            fails  = fails + 1;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have port clk  input  1  pipeline clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port id_rs1 / id_rs2  input  rv32i_reg  source registers of the instruction in ID.
REQ-004 SHALL have port id_uses_rs1 / id_uses_rs2  input  1  ID instruction actually reads rs1/rs2.
REQ-005 SHALL have port ex_rd  input  rv32i_reg  destination of the instruction in EX.
REQ-006 SHALL have port ex_is_load  input  1  EX instruction is a load.
REQ-007 SHALL have port ex_br_taken  input  1  EX resolved a taken branch or jump.
REQ-008 SHALL have port imem_req / imem_resp  input  1 each  instruction-side request and one-cycle response pulse.
REQ-009 SHALL have port dmem_req / dmem_resp  input  1 each  data-side request (read or write) and one-cycle response pulse.
REQ-010 SHALL have port load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb  output  1 each  pipeline register enables.
REQ-011 SHALL have port flush_if_id / flush_id_ex  output  1 each  replace the register's next contents with a NOP.
REQ-012 SHALL have port ctrl_state_o  output  2  current FSM state, for debug.

Function
REQ-013 SHALL implement FSM states RUN (2'b00) and MEM_WAIT (2'b01); codes 2'b10 and 2'b11 SHALL be unused and SHALL return to RUN.
REQ-014 SHALL keep sticky flags imem_done and dmem_done, set by the corresponding resp pulse while in MEM_WAIT and cleared on leaving MEM_WAIT.
REQ-015 SHALL define outstanding_i = imem_req & ~imem_resp & ~imem_done; outstanding_d = dmem_req & ~dmem_resp & ~dmem_done.
REQ-016 In RUN, if outstanding_i | outstanding_d, all load_* SHALL be 0 and all flush_* 0 in that same cycle, and the next state SHALL be MEM_WAIT.
REQ-017 In MEM_WAIT, while outstanding_i | outstanding_d, all load_* and flush_* SHALL be 0.
REQ-018 In MEM_WAIT, in the cycle both sides are satisfied (including a resp arriving that cycle), the outputs SHALL equal the RUN no-miss outputs (REQ-019..REQ-021), and the next state SHALL be RUN.
REQ-019 With no miss pending, if ex_br_taken = 1: all load_* SHALL be 1, and flush_if_id = flush_id_ex = 1; this takes priority over load-use.
REQ-020 With no miss pending and ex_br_taken = 0, load-use SHALL be ex_is_load & ex_rd != 0 & ((id_uses_rs1 & ex_rd == id_rs1) | (id_uses_rs2 & ex_rd == id_rs2)); on load-use, load_pc = load_if_id = 0, flush_id_ex = 1, and all other load_* = 1, giving exactly one bubble per hazard.
REQ-021 Otherwise all load_* SHALL be 1 and all flush_* 0.
REQ-022 Requesters SHALL hold req high until their resp; a resp without a req SHALL be ignored.
REQ-023 imem and dmem responses arriving in different cycles SHALL be merged through the sticky flags; release occurs only after the later of the two.
REQ-024 Outputs SHALL be combinational from state, flags and inputs, with zero-cycle latency to stall.

Reset
REQ-025 While rst_n = 0: state = RUN, both flags = 0, all load_* = 0, all flush_* = 0, ctrl_state_o = 0, and counters = 0.
REQ-026 Reset asserted during MEM_WAIT SHALL abandon the wait immediately; the first cycle after release SHALL evaluate in RUN.

Configuration
REQ-027 With PIPE_CTRL_PERF_EN defined, the block SHALL add 32-bit outputs perf_stall_cycles (increments in every cycle where load_pc = 0), perf_lu_count (increments per load-use bubble) and perf_flush_count (increments per cycle with flush_if_id = 1); each SHALL wrap from 0xFFFFFFFF to 0.
REQ-028 Without PIPE_CTRL_PERF_EN, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-029 The FSM state enum (ctrl_state_t) SHALL live in rv32i_types; the block SHALL reuse rv32i_reg from that package.
REQ-030 The hazard comparison SHALL be a sub-module hazard_detect (combinational, load-use only); the FSM, flags and counters SHALL stay in pipeline_ctrl.

Verification
REQ-031 The bench SHALL check: ex_is_load = 1, ex_rd = 5, id_rs1 = 5, id_uses_rs1 = 1 -> one cycle of load_pc = 0, load_if_id = 0, flush_id_ex = 1; the next cycle has all load_* = 1.
REQ-032 The bench SHALL check: the same as REQ-031 but ex_rd = 0 -> no stall, all load_* = 1.
REQ-033 The bench SHALL check: imem_req and dmem_req high, imem_resp at cycle 3, dmem_resp at cycle 6 -> load_* = 0 in cycles 0-5, all 1 in cycle 6, and state = RUN in cycle 7.
REQ-034 The bench SHALL check: ex_br_taken = 1 with a simultaneous load-use match -> flush_if_id = flush_id_ex = 1, all load_* = 1.
REQ-035 The bench SHALL check: ex_br_taken = 1 during a dmem miss of 4 cycles -> no flush for 4 cycles, then a single flush in the release cycle.
REQ-036 The bench SHALL check: with PIPE_CTRL_PERF_EN, perf_stall_cycles preloaded to 0xFFFFFFFF plus one stall cycle -> reads 0; rst_n low mid-MEM_WAIT -> state 0, outputs 0.
